// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 16-bit timer with compare match, auto-reload/one-shot and level irq
//
// Optional feature: define CAPTURE_EN to add the cap_in synchronizer, the CAPT register (offset 5)
// and STATUS.cap_flag; without it cap_in is ignored and offset 5 is unmapped.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   en             bus access strobe
//   write_enable   1=write, 0=read (qualified by en)
//   byte_enable    1=byte write
//   byte_select    byte lane for byte write: 0=[7:0], 1=[15:8]
//   addr           word address
//   data_in        write data
//   cap_in         asynchronous capture input
//   data_out       registered read data
//   serviced_read  one-cycle pulse when data_out was produced here
//   irq            registered level interrupt
module mmio_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h7FF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        write_enable,
    input  logic        byte_enable,
    input  logic        byte_select,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        cap_in,
    output logic [15:0] data_out,
    output logic        serviced_read,
    output logic        irq
);
    logic        hit, wr, rd, lo, hi, mapped, tick, is_match, cap_rise;
    logic [2:0]  off;
    logic        run, autoreload, irq_en, match, cap_flag;
    logic [15:0] presc, pc, count, cmp, capt, rdata;

    // Merge write data into a register honouring the byte lanes
    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic l, input logic h);
        return {h ? d[15:8] : old[15:8], l ? d[7:0] : old[7:0]};
    endfunction

    assign hit      = en && addr[15:3] == BASE_ADDR[15:3];
    assign off      = addr[2:0];
    assign wr       = hit && write_enable;
    assign rd       = hit && !write_enable;
    assign lo       = !byte_enable || !byte_select;
    assign hi       = !byte_enable || byte_select;
    assign tick     = run && pc == presc;
    assign is_match = count == cmp;

`ifdef CAPTURE_EN
    logic [2:0] cap_sync;
    assign mapped   = off <= 3'd5;
    // Two flops synchronize, the third holds the previous synchronized level for edge detection
    assign cap_rise = cap_sync[1] & ~cap_sync[2];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_sync <= '0;
            capt     <= '0;
        end else begin
            cap_sync <= {cap_sync[1:0], cap_in};
            if (cap_rise) capt <= count;
        end
    end
`else
    logic unused_cap;
    assign unused_cap = cap_in;
    assign mapped     = off <= 3'd4;
    assign cap_rise   = 1'b0;
    assign capt       = '0;
`endif

    always_comb begin
        rdata = off == 3'd0 ? {13'b0, irq_en, autoreload, run} :
                off == 3'd1 ? presc :
                off == 3'd2 ? count :
                off == 3'd3 ? cmp :
                off == 3'd4 ? {14'b0, cap_flag, match} : capt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run           <= 1'b0;
            autoreload    <= 1'b0;
            irq_en        <= 1'b0;
            match         <= 1'b0;
            cap_flag      <= 1'b0;
            presc         <= '0;
            pc            <= '0;
            count         <= '0;
            cmp           <= '0;
            data_out      <= '0;
            serviced_read <= 1'b0;
            irq           <= 1'b0;
        end else begin
            pc <= (!run || tick || (wr && off == 3'd1)) ? '0 : pc + 16'd1;
            // One-shot stop first so a same-cycle CTRL write overrides it
            if (tick && is_match && !autoreload) run <= 1'b0;
            if (wr && off == 3'd0 && lo) {irq_en, autoreload, run} <= data_in[2:0];
            if (wr && off == 3'd1) presc <= merge(presc, data_in, lo, hi);
            if (wr && off == 3'd3) cmp <= merge(cmp, data_in, lo, hi);
            if (wr && off == 3'd2) count <= merge(count, data_in, lo, hi);
            else if (tick) count <= is_match ? (autoreload ? '0 : count) : count + 16'd1;
            // W1C first; hardware sets below take precedence
            if (wr && off == 3'd4 && lo) begin
                if (data_in[0]) match <= 1'b0;
                if (data_in[1]) cap_flag <= 1'b0;
            end
            if (tick && is_match) match <= 1'b1;
            if (cap_rise) cap_flag <= 1'b1;
            irq           <= match & irq_en;
            serviced_read <= rd && mapped;
            if (rd && mapped) data_out <= rdata;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer
module tb_mmio_timer;
    localparam logic [15:0] B = 16'h7FF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, write_enable = 1'b0, byte_enable = 1'b0, byte_select = 1'b0, cap_in = 1'b0;
    logic [15:0] addr = '0, data_in = '0;
    logic [15:0] data_out;
    logic        serviced_read, irq;
    int          total = 0, bad = 0;
    logic [15:0] d;
    logic        s;

    mmio_timer #(.BASE_ADDR(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .write_enable(write_enable),
        .byte_enable(byte_enable), .byte_select(byte_select), .addr(addr),
        .data_in(data_in), .cap_in(cap_in), .data_out(data_out),
        .serviced_read(serviced_read), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v, input logic be, input logic bs);
        en = 1'b1; write_enable = 1'b1; addr = a; data_in = v; byte_enable = be; byte_select = bs;
        @(negedge clk);
        en = 1'b0; write_enable = 1'b0; byte_enable = 1'b0; byte_select = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v, output logic sv);
        en = 1'b1; write_enable = 1'b0; addr = a;
        @(negedge clk);
        v = data_out; sv = serviced_read;
        en = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; write_enable = 1'b1; addr = B; data_in = 16'h0007;
        idle(2);
        total++; if (data_out !== 16'h0) begin bad++; $display("FAIL rst_data_out got %h exp 0000", data_out); end
        total++; if (serviced_read !== 1'b0) begin bad++; $display("FAIL rst_serviced got %b exp 0", serviced_read); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got %b exp 0", irq); end
        write_enable = 1'b0;
        idle(1);
        total++; if (serviced_read !== 1'b0) begin bad++; $display("FAIL rst_read_ignored got %b exp 0", serviced_read); end
        en = 1'b0; rst_n = 1'b1;
        idle(1);
        for (int o = 0; o < 5; o++) begin
            rd(B | 16'(o), d, s);
            total++; if (d !== 16'h0) begin bad++; $display("FAIL rst_reg%0d got %h exp 0000", o, d); end
            total++; if (s !== 1'b1) begin bad++; $display("FAIL rst_svc%0d got %b exp 1", o, s); end
        end
        idle(1);
        total++; if (serviced_read !== 1'b0) begin bad++; $display("FAIL svc_pulse_end got %b exp 0", serviced_read); end
    endtask

    task automatic test_autoreload;
        do_reset;
        wr(B | 16'd1, 16'd3, 1'b0, 1'b0);
        wr(B | 16'd3, 16'd2, 1'b0, 1'b0);
        wr(B | 16'd0, 16'h0007, 1'b0, 1'b0);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL ar_count0 got %h exp 0000", d); end
        idle(3);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'd1) begin bad++; $display("FAIL ar_count1 got %h exp 0001", d); end
        idle(3);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'd2) begin bad++; $display("FAIL ar_count2 got %h exp 0002", d); end
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL ar_no_match_yet got %h exp 0000", d); end
        idle(2);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq_delay got %b exp 0", irq); end
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'd1) begin bad++; $display("FAIL ar_match got %h exp 0001", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ar_irq got %b exp 1", irq); end
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL ar_reload got %h exp 0000", d); end
        wr(B | 16'd0, 16'h0000, 1'b0, 1'b0);
        wr(B | 16'd4, 16'h0001, 1'b0, 1'b0);
        idle(1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq_clear got %b exp 0", irq); end
    endtask

    task automatic test_oneshot;
        do_reset;
        wr(B | 16'd3, 16'd1, 1'b0, 1'b0);
        wr(B | 16'd0, 16'h0001, 1'b0, 1'b0);
        idle(2);
        rd(B | 16'd0, d, s);
        total++; if (d !== 16'd0) begin bad++; $display("FAIL os_run_clear got %h exp 0000", d); end
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'd1) begin bad++; $display("FAIL os_count got %h exp 0001", d); end
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'd1) begin bad++; $display("FAIL os_match got %h exp 0001", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL os_irq_masked got %b exp 0", irq); end
        idle(4);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'd1) begin bad++; $display("FAIL os_count_hold got %h exp 0001", d); end
    endtask

    task automatic test_wrap;
        do_reset;
        wr(B | 16'd2, 16'hFFFF, 1'b0, 1'b0);
        wr(B | 16'd3, 16'h0005, 1'b0, 1'b0);
        wr(B | 16'd0, 16'h0001, 1'b0, 1'b0);
        wr(B | 16'd0, 16'h0000, 1'b0, 1'b0);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL wrap_count got %h exp 0000", d); end
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL wrap_no_match got %h exp 0000", d); end
    endtask

    task automatic test_byte_w1c;
        do_reset;
        wr(B | 16'd2, 16'hAB00, 1'b1, 1'b1);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'hAB00) begin bad++; $display("FAIL byte_hi got %h exp ab00", d); end
        wr(B | 16'd2, 16'h12CD, 1'b1, 1'b0);
        rd(B | 16'd2, d, s);
        total++; if (d !== 16'hABCD) begin bad++; $display("FAIL byte_lo got %h exp abcd", d); end
        wr(B | 16'd0, 16'hFF00, 1'b1, 1'b1);
        rd(B | 16'd0, d, s);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL byte_ctrl_hi got %h exp 0000", d); end
        wr(B | 16'd2, 16'h0000, 1'b0, 1'b0);
        wr(B | 16'd0, 16'h0003, 1'b0, 1'b0);
        wr(B | 16'd4, 16'h0001, 1'b0, 1'b0);
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'h0001) begin bad++; $display("FAIL w1c_vs_set got %h exp 0001", d); end
        wr(B | 16'd0, 16'h0000, 1'b0, 1'b0);
        wr(B | 16'd4, 16'h0001, 1'b0, 1'b0);
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL w1c_clear got %h exp 0000", d); end
    endtask

    task automatic test_capture;
        do_reset;
        wr(B | 16'd2, 16'd7, 1'b0, 1'b0);
        cap_in = 1'b1;
        idle(3);
`ifdef CAPTURE_EN
        rd(B | 16'd5, d, s);
        total++; if (d !== 16'd7 || s !== 1'b1) begin bad++; $display("FAIL capt got %h/%b exp 0007/1", d, s); end
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'h0002) begin bad++; $display("FAIL cap_flag got %h exp 0002", d); end
`else
        rd(B | 16'd5, d, s);
        total++; if (s !== 1'b0) begin bad++; $display("FAIL capt_unmapped got %b exp 0", s); end
        rd(B | 16'd4, d, s);
        total++; if (d !== 16'h0000 || s !== 1'b1) begin bad++; $display("FAIL cap_flag_off got %h/%b exp 0000/1", d, s); end
`endif
        cap_in = 1'b0;
    endtask

    task automatic test_decode;
        do_reset;
        wr(B | 16'd3, 16'h1234, 1'b0, 1'b0);
        rd(B | 16'd3, d, s);
        total++; if (d !== 16'h1234 || s !== 1'b1) begin bad++; $display("FAIL dec_cmp got %h/%b exp 1234/1", d, s); end
        rd(B | 16'd6, d, s);
        total++; if (d !== 16'h1234 || s !== 1'b0) begin bad++; $display("FAIL dec_unmapped got %h/%b exp 1234/0", d, s); end
        rd(16'h7FE3, d, s);
        total++; if (s !== 1'b0) begin bad++; $display("FAIL dec_miss_rd got %b exp 0", s); end
        wr(16'h7FEB, 16'h5555, 1'b0, 1'b0);
        rd(B | 16'd3, d, s);
        total++; if (d !== 16'h1234) begin bad++; $display("FAIL dec_miss_wr got %h exp 1234", d); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_autoreload;
        test_oneshot;
        test_wrap;
        test_byte_w1c;
        test_capture;
        test_decode;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
